apb_completer: RTL and testbench

APB completer that terminates transfers from the DFE APB bridge and exposes a small memory-mapped register bank to the filter array. It decodes word-aligned addresses, inserts a parameterised number of wait states, flags illegal accesses with PSLVERR, and signals each committed register write with a one-cycle strobe. One instance sits behind each PSELx line of the bridge.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_reg_bank.sv | 64 ++++++
 rtl/apb_completer.sv | 127 ++++++++++++
 tb/tb_apb_completer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the DFE APB completer: FSM state encoding,
// the status register index helper and the DFE control register byte offsets.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } apb_state_e;

   // Byte offsets of the DFE filter-array control registers
   localparam logic [7:0] COEF_SEL_OFS = 8'h00;
   localparam logic [7:0] BYPASS_OFS   = 8'h04;
   localparam logic [7:0] GAIN_OFS     = 8'h08;

   // The last register of the bank is the read-only status word
   function automatic int status_idx(input int num_regs);
      return num_regs - 1;
   endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array behind the completer: write port, one-hot write strobe and
// read mux. The top entry is the live status word and is never stored.
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_REGS   = 8,
   localparam int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_wr_en,
   input  logic [IDX_W-1:0]               i_wr_idx,
   input  logic [DATA_WIDTH-1:0]          i_wr_data,
   input  logic [IDX_W-1:0]               i_rd_idx,
   input  logic [DATA_WIDTH-1:0]          i_status,
   output logic [DATA_WIDTH-1:0]          o_rd_data,
   output logic [NUM_REGS*DATA_WIDTH-1:0] o_ctrl_regs,
   output logic [NUM_REGS-1:0]            o_wr_strobe
);

   localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(status_idx(NUM_REGS));

   logic [NUM_REGS-2:0][DATA_WIDTH-1:0] r_regs;
   logic [NUM_REGS-1:0]                 r_strobe;
   logic                                w_wr_ok;
   logic [NUM_REGS-1:0]                 w_onehot;

   assign w_wr_ok  = i_wr_en && (i_wr_idx != STATUS_IDX);
   assign w_onehot = NUM_REGS'(1) << i_wr_idx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_regs   <= '0;
         r_strobe <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS-1; i++) begin
            if (w_wr_ok && (i_wr_idx == IDX_W'(i))) r_regs[i] <= i_wr_data;
         end
         r_strobe <= w_wr_ok ? w_onehot : '0;
      end
   end

   generate
      for (genvar g = 0; g < NUM_REGS-1; g++) begin : g_flat
         assign o_ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
      end
   endgenerate
   assign o_ctrl_regs[(NUM_REGS-1)*DATA_WIDTH +: DATA_WIDTH] = '0;
   assign o_wr_strobe = r_strobe;

   // Combinational read: a same-cycle write is only visible after the edge
   always_comb begin
      o_rd_data = '0;
      if (i_rd_idx == STATUS_IDX) begin
         o_rd_data = i_status;
      end else begin
         for (int i = 0; i < NUM_REGS-1; i++) begin
            if (i_rd_idx == IDX_W'(i)) o_rd_data = r_regs[i];
         end
      end
   end

endmodule

// File: rtl/apb_completer.sv
// APB completer for one PSELx line of the DFE bridge: address decode, error
// flagging, programmable wait states and hand-off to the register bank.
module apb_completer
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                           PCLK,
   input  logic                           PRESETn,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PREADY,
   output logic                           PSLVERR,
   input  logic [DATA_WIDTH-1:0]          status_in,
   output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
   output logic [NUM_REGS-1:0]            wr_strobe
);

   localparam int                    IDX_W      = $clog2(NUM_REGS);
   localparam logic [IDX_W-1:0]      STATUS_IDX = IDX_W'(status_idx(NUM_REGS));
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS*4);
   localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_CYCLES);

   apb_state_e             r_state, w_state_nxt;
   logic [3:0]             r_cnt, w_cnt_nxt;
   logic                   r_write;
   logic                   r_err;
   logic [IDX_W-1:0]       r_idx;
   logic [DATA_WIDTH-1:0]  r_wdata;

   logic                   w_setup, w_access, w_capture;
   logic [IDX_W-1:0]       w_idx;
   logic                   w_err;
   logic                   w_commit;
   logic [DATA_WIDTH-1:0]  w_rd_data;

   assign w_setup   = PSEL && !PENABLE;
   assign w_access  = PSEL && PENABLE;
   assign w_capture = (r_state == IDLE) && w_setup;

   assign w_idx = PADDR[2 +: IDX_W];
   assign w_err = (PADDR[1:0] != 2'b00) || (PADDR >= ADDR_LIMIT) ||
                  (PWRITE && (w_idx == STATUS_IDX));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_setup) begin
               if (WAIT_LOAD != 4'd0) begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = WAIT_LOAD;
               end else begin
                  w_state_nxt = READY;
               end
            end
         end
         WAIT: begin
            // Only real access-phase cycles count toward the wait budget
            if (!PSEL) begin
               w_state_nxt = IDLE;
            end else if (w_access) begin
               w_cnt_nxt = r_cnt - 4'd1;
               if (r_cnt <= 4'd1) w_state_nxt = READY;
            end
         end
         READY: begin
            if (!PSEL || w_access) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else if (w_capture) begin
         r_write <= PWRITE;
         r_err   <= w_err;
         r_idx   <= w_idx;
         r_wdata <= PWDATA;
      end
   end

   assign PREADY   = (r_state == READY) && PSEL && PENABLE;
   assign PSLVERR  = PREADY && r_err;
   assign w_commit = PREADY && r_write && !r_err;
   assign PRDATA   = (PREADY && !r_write && !r_err) ? w_rd_data : '0;

   apb_reg_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_reg_bank (
      .i_clk       (PCLK),
      .i_rst_n     (PRESETn),
      .i_wr_en     (w_commit),
      .i_wr_idx    (r_idx),
      .i_wr_data   (r_wdata),
      .i_rd_idx    (r_idx),
      .i_status    (status_in),
      .o_rd_data   (w_rd_data),
      .o_ctrl_regs (ctrl_regs),
      .o_wr_strobe (wr_strobe)
   );

endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer: two instances (0 and 3 wait states) on separate
// PSEL lines, directed cases plus random traffic against a transfer-level model.
module tb_apb_completer;

   logic              pclk = 1'b0;
   logic              prstn;
   logic [1:0]        psel;
   logic              penable, pwrite;
   logic [31:0]       paddr, pwdata, status_in;
   logic [1:0]        pready, pslverr;
   logic [1:0][31:0]  prdata;
   logic [1:0][255:0] ctrl;
   logic [1:0][7:0]   strobe;
   bit                st_rand;

   int tests = 0;
   int fails = 0;

   // Transfer-level model state per instance
   logic [31:0] m_regs [2][8];
   logic [7:0]  m_stb  [2];
   bit          m_pend [2];
   int          m_acc  [2];
   bit          m_wr   [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_data [2];
   bit          e_rdy, e_err;
   logic [31:0] e_rd;

   always #5 pclk = ~pclk;

   apb_completer #(.WAIT_CYCLES(0)) u_dut0 (
      .PCLK(pclk), .PRESETn(prstn), .PSEL(psel[0]), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]),
      .PREADY(pready[0]), .PSLVERR(pslverr[0]), .status_in(status_in),
      .ctrl_regs(ctrl[0]), .wr_strobe(strobe[0]));

   apb_completer #(.WAIT_CYCLES(3)) u_dut1 (
      .PCLK(pclk), .PRESETn(prstn), .PSEL(psel[1]), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]),
      .PREADY(pready[1]), .PSLVERR(pslverr[1]), .status_in(status_in),
      .ctrl_regs(ctrl[1]), .wr_strobe(strobe[1]));

   function automatic int wc(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic bit m_err(input bit wr, input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'd32) || (wr && a[4:2] == 3'd7);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   // Per-cycle compare against the model, then advance the model to the next edge
   initial begin
      forever begin
         @(negedge pclk);
         for (int d = 0; d < 2; d++) begin
            if (!prstn) begin
               m_pend[d] = 0;
               m_stb[d]  = '0;
               for (int i = 0; i < 8; i++) m_regs[d][i] = '0;
            end
            e_rdy = m_pend[d] && psel[d] && penable && (m_acc[d] == wc(d));
            e_err = e_rdy && m_err(m_wr[d], m_addr[d]);
            e_rd  = '0;
            if (e_rdy && !m_wr[d] && !e_err)
               e_rd = (m_addr[d][4:2] == 3'd7) ? status_in : m_regs[d][m_addr[d][4:2]];
            chk($sformatf("d%0d_pready", d), 32'(pready[d]), 32'(e_rdy));
            chk($sformatf("d%0d_pslverr", d), 32'(pslverr[d]), 32'(e_err));
            chk($sformatf("d%0d_prdata", d), prdata[d], e_rd);
            chk($sformatf("d%0d_strobe", d), 32'(strobe[d]), 32'(m_stb[d]));
            for (int i = 0; i < 8; i++)
               chk($sformatf("d%0d_ctrl%0d", d, i), ctrl[d][i*32 +: 32], m_regs[d][i]);
            if (prstn) begin
               m_stb[d] = '0;
               if (m_pend[d]) begin
                  if (!psel[d]) begin
                     m_pend[d] = 0;
                  end else if (penable) begin
                     if (e_rdy) begin
                        if (m_wr[d] && !e_err) begin
                           m_regs[d][m_addr[d][4:2]] = m_data[d];
                           m_stb[d] = 8'(1) << m_addr[d][4:2];
                        end
                        m_pend[d] = 0;
                     end else begin
                        m_acc[d]++;
                     end
                  end
               end else if (psel[d] && !penable) begin
                  m_pend[d] = 1;
                  m_acc[d]  = 0;
                  m_wr[d]   = pwrite;
                  m_addr[d] = paddr;
                  m_data[d] = pwdata;
               end
            end
         end
      end
   end

   task automatic upd_status();
      if (st_rand) status_in = $urandom;
   endtask

   // One transfer, entered just after a rising edge; returns just after the edge
   // that follows completion so a following call is back-to-back.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int abort_at,
                       output logic [31:0] rdata, output bit err,
                       output int nacc, output logic [7:0] stb);
      bit done;
      done = 0; rdata = '0; err = 0; nacc = 0; stb = '0;
      psel = '0; psel[d] = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = wdata;
      upd_status();
      @(posedge pclk); #1;
      penable = 1'b1;
      pwdata  = $urandom;
      upd_status();
      while (!done) begin
         @(negedge pclk);
         nacc++;
         if (pready[d]) begin
            rdata = prdata[d];
            err   = pslverr[d];
            done  = 1;
            @(posedge pclk); #1;
            stb  = strobe[d];
            psel = '0; penable = 1'b0;
            upd_status();
         end else if (nacc == abort_at || nacc > 40) begin
            if (nacc > 40) begin
               tests++; fails++;
               $display("FAIL d%0d_timeout: no PREADY after %0d access cycles", d, nacc);
            end
            done = 1;
            @(posedge pclk); #1;
            psel = '0; penable = 1'b0;
            @(posedge pclk); #1;
         end else begin
            @(posedge pclk); #1;
            upd_status();
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge pclk); #1;
         upd_status();
      end
   endtask

   logic [31:0] rd, addr;
   bit          er, wr;
   int          na, d;
   logic [7:0]  sb;
   logic [31:0] err_addrs [3];

   initial begin
      prstn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; status_in = '0; st_rand = 0;
      err_addrs[0] = 32'h1C; err_addrs[1] = 32'h20; err_addrs[2] = 32'h02;
      repeat (2) @(posedge pclk);
      #1 prstn = 1'b1;
      chk("rst_ctrl1", ctrl[0][63:32], 32'h0);
      chk("rst_pready", 32'(pready), 32'h0);

      // Zero wait states: write then back-to-back read
      xfer(0, 1, 32'h04, 32'hA5A5_0001, -1, rd, er, na, sb);
      chk("w0_latency", na, 1);
      chk("w0_slverr", 32'(er), 0);
      chk("w0_strobe", 32'(sb), 32'h02);
      xfer(0, 0, 32'h04, 32'h0, -1, rd, er, na, sb);
      chk("r0_data", rd, 32'hA5A5_0001);
      chk("r0_latency", na, 1);

      // Three wait states: ready on the fourth access cycle
      xfer(1, 0, 32'h00, 32'h0, -1, rd, er, na, sb);
      chk("r3_latency", na, 4);
      chk("r3_data", rd, 32'h0);

      // Error responses: status write, out of range, misaligned
      for (int i = 0; i < 3; i++) begin
         xfer(0, 1, err_addrs[i], 32'hFFFF_FFFF, -1, rd, er, na, sb);
         chk($sformatf("err%0d_slverr", i), 32'(er), 1);
         chk($sformatf("err%0d_strobe", i), 32'(sb), 0);
      end
      chk("err_keep1", ctrl[0][63:32], 32'hA5A5_0001);
      chk("err_keep0", ctrl[0][31:0], 32'h0);
      chk("err_keep7", ctrl[0][255:224], 32'h0);

      // Status read returns the live input
      status_in = 32'hDEAD_BEEF;
      xfer(0, 0, 32'h1C, 32'h0, -1, rd, er, na, sb);
      chk("stat_data", rd, 32'hDEAD_BEEF);
      chk("stat_slverr", 32'(er), 0);

      // Back-to-back write/read of 0x08 with no idle cycle
      xfer(0, 1, 32'h08, 32'h1234_5678, -1, rd, er, na, sb);
      chk("b2b_strobe", 32'(sb), 32'h04);
      xfer(0, 0, 32'h08, 32'h0, -1, rd, er, na, sb);
      chk("b2b_data", rd, 32'h1234_5678);

      // Abort during wait states: nothing committed
      xfer(1, 1, 32'h0C, 32'hCAFE_0001, 2, rd, er, na, sb);
      idle(2);
      chk("abort_reg", ctrl[1][127:96], 32'h0);
      chk("abort_strobe", 32'(strobe[1]), 32'h0);
      xfer(1, 1, 32'h0C, 32'hCAFE_0002, -1, rd, er, na, sb);
      chk("post_abort_lat", na, 4);
      chk("post_abort_stb", 32'(sb), 32'h08);
      idle(1);
      chk("post_abort_reg", ctrl[1][127:96], 32'hCAFE_0002);

      // Asynchronous reset in the middle of a completing access
      psel = 2'b01; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
      @(posedge pclk); #1 penable = 1'b1;
      #1 chk("prerst_pready", 32'(pready[0]), 1);
      #1 prstn = 1'b0;
      #1;
      chk("arst_pready", 32'(pready[0]), 0);
      chk("arst_prdata", prdata[0], 32'h0);
      chk("arst_ctrl1", ctrl[0][63:32], 32'h0);
      chk("arst_ctrl3", ctrl[1][127:96], 32'h0);
      psel = '0; penable = 1'b0;
      @(posedge pclk); #1;
      @(posedge pclk); #1 prstn = 1'b1;

      // Random traffic on both completers
      st_rand = 1;
      for (int n = 0; n < 300; n++) begin
         d  = $urandom_range(0, 1);
         wr = $urandom_range(0, 1);
         case ($urandom_range(0, 6))
            0, 1, 2: addr = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            3:       addr = 32'h1C;
            4:       addr = 32'h20 + (32'($urandom_range(0, 31)) << 2);
            5:       addr = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(1, 3))};
            default: addr = $urandom;
         endcase
         xfer(d, wr, addr, $urandom, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : -1,
              rd, er, na, sb);
         idle($urandom_range(0, 2));
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", tests);
      $fatal(1, "watchdog");
   end

endmodule
